// File: rtl/toggle_event_rx_if.sv
// rtl/toggle_event_rx_if.sv - valid/ready event drain port carrying the pending count
interface toggle_event_rx_if #(
  parameter int CNT_W = 4
);
  logic             ev_valid;
  logic             ev_ready;
  logic [CNT_W-1:0] pending;

  modport master (output ev_valid, output pending, input ev_ready);
  modport slave  (input ev_valid, input pending, output ev_ready);
endinterface

// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - toggle-line receiver: resync, edge detect, saturating event queue
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              toggle_i,
  output logic              event_pulse_o,
  output logic              overflow_o,
  input  logic              clr_overflow_i,
  toggle_event_rx_if.master ev_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_out;
  logic             prev_q;
  logic             evt;
  logic             pop;
  logic             pulse_q;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             overflow_q;
  logic             overflow_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = toggle_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Chain resets to the sender's POR level so a matching line yields no spurious event.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
          sync_q[0] <= toggle_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign evt            = sync_out ^ prev_q;
  assign ev_if.ev_valid = (pending_q != '0);
  assign ev_if.pending  = pending_q;
  assign pop            = ev_if.ev_valid & ev_if.ev_ready;
  assign event_pulse_o  = pulse_q;
  assign overflow_o     = overflow_q;

  // A drop sets overflow after the clear is applied, so set wins over a coincident clear.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end
    if (evt && !pop) begin
      if (pending_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_ONE;
      end
    end else if (!evt && pop) begin
      pending_d = pending_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= INIT_LEVEL;
      pulse_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= sync_out;
      pulse_q    <= evt;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - directed and randomized checks of toggle_event_rx against a level-history model
module tb_toggle_event_rx;

  localparam int SYNC   = 2;
  localparam int CNT_W  = 4;
  localparam bit INIT   = 1'b0;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic toggle_i;
  logic event_pulse_o;
  logic overflow_o;
  logic clr_overflow_i;

  toggle_event_rx_if #(.CNT_W(CNT_W)) ev_if ();

  toggle_event_rx #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (CNT_W),
    .INIT_LEVEL  (INIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .toggle_i       (toggle_i),
    .event_pulse_o  (event_pulse_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i),
    .ev_if          (ev_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: toggle level seen at each edge since reset release, plus queue occupancy and flag.
  bit hist[$];
  int m_pend;
  bit m_ovf;
  bit m_pulse;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit lvl(input int j);
    if (j <= 0) return INIT;
    return hist[j-1];
  endfunction

  // A transition between the levels applied before edges j-1 and j lands at edge j+SYNC.
  task automatic model_edge();
    int  m;
    bit  evt;
    bit  pop;
    bit  drop;
    hist.push_back(toggle_i);
    m    = hist.size();
    evt  = lvl(m - SYNC) != lvl(m - SYNC - 1);
    pop  = (m_pend > 0) && ev_if.ev_ready;
    drop = 1'b0;
    if (evt && !pop) begin
      if (m_pend == MAXCNT) drop = 1'b1;
      else m_pend++;
    end else if (!evt && pop) begin
      m_pend--;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_overflow_i) m_ovf = 1'b0;
    m_pulse = evt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("pulse",    int'(event_pulse_o),  int'(m_pulse));
    check_eq("pending",  int'(ev_if.pending),  m_pend);
    check_eq("valid",    int'(ev_if.ev_valid), int'(m_pend != 0));
    check_eq("overflow", int'(overflow_o),     int'(m_ovf));
  endtask

  // Called at a negedge; asserts reset between edges and releases at the next negedge.
  task automatic do_reset(input bit lvl_at_release);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_pending",  int'(ev_if.pending),  0);
    check_eq("rst_valid",    int'(ev_if.ev_valid), 0);
    check_eq("rst_overflow", int'(overflow_o),     0);
    check_eq("rst_pulse",    int'(event_pulse_o),  0);
    hist.delete();
    m_pend  = 0;
    m_ovf   = 1'b0;
    m_pulse = 1'b0;
    toggle_i = lvl_at_release;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int rdy_pct [5] = '{10, 30, 60, 5, 50};

    rst_n          = 1'b0;
    toggle_i       = 1'b0;
    ev_if.ev_ready = 1'b0;
    clr_overflow_i = 1'b0;
    m_pend         = 0;
    m_ovf          = 1'b0;
    m_pulse        = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("t1_pulse",    int'(event_pulse_o),  0);
    check_eq("t1_pending",  int'(ev_if.pending),  0);
    check_eq("t1_valid",    int'(ev_if.ev_valid), 0);
    check_eq("t1_overflow", int'(overflow_o),     0);
    rst_n = 1'b1;

    // Latency: change before edge 1 shows after edge 3.
    toggle_i = 1'b1;
    step(); check_eq("t2_pulse_e1", int'(event_pulse_o), 0);
    step(); check_eq("t2_pulse_e2", int'(event_pulse_o), 0);
    step(); check_eq("t2_pulse_e3", int'(event_pulse_o), 1);
    check_eq("t2_pending", int'(ev_if.pending), 1);
    step(); check_eq("t2_pulse_e4", int'(event_pulse_o), 0);
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    check_eq("t2_drained", int'(ev_if.pending), 0);
    check_eq("t2_valid",   int'(ev_if.ev_valid), 0);

    // Saturation with 17 back-to-back transitions.
    for (int i = 0; i < 17; i++) begin
      toggle_i = ~toggle_i;
      step();
    end
    repeat (SYNC) step();
    check_eq("t3_sat_pending", int'(ev_if.pending), MAXCNT);
    check_eq("t3_sat_overflow", int'(overflow_o), 1);
    ev_if.ev_ready = 1'b1;
    repeat (MAXCNT) step();
    ev_if.ev_ready = 1'b0;
    check_eq("t3_empty", int'(ev_if.pending), 0);
    check_eq("t3_ovf_sticky", int'(overflow_o), 1);

    // Refill to full, clear the flag, then event+pop at saturation.
    for (int i = 0; i < MAXCNT; i++) begin
      toggle_i = ~toggle_i;
      step();
    end
    repeat (SYNC) step();
    clr_overflow_i = 1'b1;
    step();
    clr_overflow_i = 1'b0;
    check_eq("t4_cleared", int'(overflow_o), 0);
    toggle_i = ~toggle_i;
    step(); step();
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    check_eq("t4_full_evpop", int'(ev_if.pending), MAXCNT);
    check_eq("t4_full_noovf", int'(overflow_o), 0);

    // Dropped event coincident with clear: set wins.
    toggle_i = ~toggle_i;
    step(); step();
    clr_overflow_i = 1'b1;
    step();
    clr_overflow_i = 1'b0;
    check_eq("t5_set_wins", int'(overflow_o), 1);
    check_eq("t5_pending",  int'(ev_if.pending), MAXCNT);
    clr_overflow_i = 1'b1;
    step();
    clr_overflow_i = 1'b0;
    check_eq("t5_clear", int'(overflow_o), 0);

    // Event and pop together at pending=3.
    ev_if.ev_ready = 1'b1;
    repeat (MAXCNT - 3) step();
    ev_if.ev_ready = 1'b0;
    check_eq("t4_three", int'(ev_if.pending), 3);
    toggle_i = ~toggle_i;
    step(); step();
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    check_eq("t4_three_evpop", int'(ev_if.pending), 3);

    // Async reset mid-operation with a mismatching level at release.
    toggle_i = 1'b0;
    ev_if.ev_ready = 1'b1;
    repeat (4) step();
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      toggle_i = ~toggle_i;
      step(); step();
    end
    repeat (SYNC) step();
    check_eq("t6_five", int'(ev_if.pending), 5);
    do_reset(1'b1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(event_pulse_o);
    end
    check_eq("t6_one_pulse", pulses, 1);
    check_eq("t6_pending",   int'(ev_if.pending), 1);

    // Randomized traffic with phase-varying consumer rate and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset(1'($urandom_range(1)));
      end
      if ($urandom_range(1) == 1) toggle_i = ~toggle_i;
      ev_if.ev_ready = ($urandom_range(99) < rdy_pct[i / 500]);
      clr_overflow_i = ($urandom_range(99) < 8);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
